// File: rtl/sram_ctr_ahb_pkg.sv
// Shared definitions for the SRAM controller: owner FSM encodings and
// arbitration defaults.
package sram_ctr_ahb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } owner_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 8;

endpackage

// File: rtl/sram_port_arb_starve.sv
// Port-1 starvation tracker: counts consecutive denied cycles and flags
// starvation once the count reaches MAX_WAIT.
module sram_port_arb_starve
    import sram_ctr_ahb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic req1,
    input  logic gnt1,
    output logic starve
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wait_cnt <= '0;
        end else if (!req1 || gnt1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign starve = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/sram_port_arb.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency SRAM. Port 0
// normally wins and may lock across a burst; port 1 is force-granted when starved.
module sram_port_arb
    import sram_ctr_ahb_pkg::*;
#(
    parameter int unsigned AW       = 13,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic            req0_i,
    input  logic            req1_i,
    input  logic            we0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   addr0_i,
    input  logic [AW-1:0]   addr1_i,
    input  logic [DW-1:0]   wdata0_i,
    input  logic [DW-1:0]   wdata1_i,
    input  logic [DW/8-1:0] wstrb0_i,
    input  logic [DW/8-1:0] wstrb1_i,
    input  logic            lock0_i,
    output logic            gnt0_o,
    output logic            gnt1_o,
    output logic            rvalid0_o,
    output logic            rvalid1_o,
    output logic [DW-1:0]   rdata_o,
    output logic            sram_cs_o,
    output logic            sram_we_o,
    output logic [AW-1:0]   sram_addr_o,
    output logic [DW-1:0]   sram_wdata_o,
    output logic [DW/8-1:0] sram_wstrb_o,
    input  logic [DW-1:0]   sram_rdata_i
);

    owner_e state;
    logic   starve;
    logic   lock_hold;

    sram_port_arb_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .hclk    (hclk),
        .hresetn (hresetn),
        .req1    (req1_i),
        .gnt1    (gnt1_o),
        .starve  (starve)
    );

    // Port 0 keeps the SRAM through BUSY beats of a locked burst unless port 1 starves.
    assign lock_hold = (state == OWN0) && lock0_i;
    assign gnt1_o    = req1_i && (starve || (!req0_i && !lock_hold));
    assign gnt0_o    = req0_i && !gnt1_o;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        sram_cs_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wstrb_o = '0;
        if (gnt0_o) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = we0_i;
            sram_addr_o  = addr0_i;
            sram_wdata_o = wdata0_i;
            sram_wstrb_o = wstrb0_i;
        end else if (gnt1_o) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = we1_i;
            sram_addr_o  = addr1_i;
            sram_wdata_o = wdata1_i;
            sram_wstrb_o = wstrb1_i;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= IDLE;
            rvalid0_o <= 1'b0;
            rvalid1_o <= 1'b0;
        end else begin
            if (gnt0_o)         state <= OWN0;
            else if (gnt1_o)    state <= OWN1;
            else if (lock_hold) state <= OWN0;
            else                state <= IDLE;
            rvalid0_o <= gnt0_o && !we0_i;
            rvalid1_o <= gnt1_o && !we1_i;
        end
    end

    assign rdata_o = sram_rdata_i;

endmodule
